// File: rtl/bram_stream_reader.sv
// Streams a (start address, length) window out of a registered-read block RAM as valid/ready words.
// Optional BRAM_READER_LAST_EN adds an m_last flag marking the final word of each command.
module bram_stream_reader #(
   parameter int WORD_LEN = 32,
   parameter int DEPTH    = 256,
   parameter int AW       = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [AW-1:0]       cmd_addr,
   input  logic [AW:0]         cmd_len,
   output logic                enb,
   output logic [AW-1:0]       addrb,
   input  logic [WORD_LEN-1:0] dob,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [WORD_LEN-1:0] m_data,
`ifdef BRAM_READER_LAST_EN
   output logic                m_last,
`endif
   output logic                busy
);

   // state | meaning
   // IDLE  | waiting for a command, cmd_ready high
   // RUN   | issuing reads while the output buffer has room
   // DRAIN | all reads issued, waiting for buffer and pipeline to empty
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);

   state_t              state;
   logic [AW-1:0]       rd_addr;
   logic [AW-1:0]       addr_hold;
   logic [AW:0]         remaining;
   logic                inflight;
   logic [WORD_LEN-1:0] fifo_data [3];
   logic [1:0]          wr_ptr;
   logic [1:0]          rd_ptr;
   logic [1:0]          count;
   logic [1:0]          count_next;
   logic                issue;
   logic                push;
   logic                pop;
`ifdef BRAM_READER_LAST_EN
   logic                fifo_last [3];
   logic                last_inflight;
`endif

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Issue decision uses only registered occupancy, so m_ready never reaches the RAM port.
   assign issue = (state == S_RUN) && (({1'b0, count} + {2'b00, inflight}) < 3'd3);
   assign push  = inflight;
   assign pop   = m_valid & m_ready;

   always_comb begin
      count_next = count;
      if (push && !pop)
         count_next = count + 2'd1;
      else if (!push && pop)
         count_next = count - 2'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         rd_addr   <= '0;
         addr_hold <= '0;
         remaining <= '0;
         inflight  <= 1'b0;
         wr_ptr    <= 2'd0;
         rd_ptr    <= 2'd0;
         count     <= 2'd0;
         for (int i = 0; i < 3; i++) fifo_data[i] <= '0;
`ifdef BRAM_READER_LAST_EN
         last_inflight <= 1'b0;
         for (int i = 0; i < 3; i++) fifo_last[i] <= 1'b0;
`endif
      end else begin
         inflight <= issue;
`ifdef BRAM_READER_LAST_EN
         last_inflight <= issue && (remaining == LEN_ONE);
`endif
         if (push) begin
            fifo_data[wr_ptr] <= dob;
`ifdef BRAM_READER_LAST_EN
            fifo_last[wr_ptr] <= last_inflight;
`endif
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
         count <= count_next;

         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  rd_addr   <= cmd_addr;
                  remaining <= cmd_len;
                  if (cmd_len != '0)
                     state <= S_RUN;
               end
            end
            S_RUN: begin
               if (issue) begin
                  addr_hold <= rd_addr;
                  rd_addr   <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
                  remaining <= remaining - LEN_ONE;
                  if (remaining == LEN_ONE)
                     state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (!inflight && (count_next == 2'd0))
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign enb       = issue;
   assign addrb     = issue ? rd_addr : addr_hold;
   assign m_valid   = (count != 2'd0);
   assign m_data    = fifo_data[rd_ptr];
`ifdef BRAM_READER_LAST_EN
   assign m_last    = fifo_last[rd_ptr];
`endif
   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_bram_stream_reader.sv
// Scoreboard bench for bram_stream_reader: a RAM model feeds dob, expected words are queued per command.
module tb_bram_stream_reader;
   localparam int WL    = 32;
   localparam int DEPTH = 256;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic [AW:0]   cmd_len = '0;
   logic          enb;
   logic [AW-1:0] addrb;
   logic [WL-1:0] dob = '0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [WL-1:0] m_data;
   logic          m_last_s;
   logic          busy;

   always #5 clk = ~clk;

   bram_stream_reader #(.WORD_LEN(WL), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .enb(enb), .addrb(addrb), .dob(dob),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
`ifdef BRAM_READER_LAST_EN
      .m_last(m_last_s),
`endif
      .busy(busy)
   );
`ifndef BRAM_READER_LAST_EN
   assign m_last_s = 1'b0;
`endif

   logic [WL-1:0] ram [DEPTH];
   always @(posedge clk) if (enb) dob <= ram[addrb];

   typedef struct { logic [WL-1:0] d; logic l; } exp_t;
   exp_t          sbq[$];
   logic [AW-1:0] addr_log[$];
   int            enb_cnt = 0;
   int            errors = 0;
   int            checks = 0;
   logic          rand_mode = 1'b0;
   logic          prev_hold = 1'b0;
   logic [WL-1:0] prev_data;
   logic          prev_last;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on each handshake and enforces the stall-stability rule.
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (enb) begin
            enb_cnt++;
            addr_log.push_back(addrb);
         end
         if (prev_hold) begin
            check("stall_valid", {63'd0, m_valid}, 64'd1);
            check("stall_data", {32'd0, m_data}, {32'd0, prev_data});
`ifdef BRAM_READER_LAST_EN
            check("stall_last", {63'd0, m_last_s}, {63'd0, prev_last});
`endif
         end
         if (m_valid && m_ready) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_word: got %0h expected no word", m_data);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               check("word_data", {32'd0, m_data}, {32'd0, e.d});
`ifdef BRAM_READER_LAST_EN
               check("word_last", {63'd0, m_last_s}, {63'd0, e.l});
`endif
            end
         end
         prev_hold = m_valid && !m_ready;
         prev_data = m_data;
         prev_last = m_last_s;
      end
   end

   always @(posedge clk) begin
      if (rand_mode) begin
         #1;
         m_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic send_cmd(input logic [AW-1:0] a, input int l);
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_len   = (AW+1)'(l);
      for (int k = 0; k < l; k++) begin
         exp_t e;
         e.d = ram[(int'(a) + k) % DEPTH];
         e.l = (k == l - 1);
         sbq.push_back(e);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      bit done = 0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (!busy) done = 1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got busy after %0d cycles expected idle", budget);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_m_valid"}, {63'd0, m_valid}, 64'd0);
      check({tag, "_m_data"}, {32'd0, m_data}, 64'd0);
      check({tag, "_m_last"}, {63'd0, m_last_s}, 64'd0);
      check({tag, "_enb"}, {63'd0, enb}, 64'd0);
      check({tag, "_addrb"}, {56'd0, addrb}, 64'd0);
      check({tag, "_busy"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] a;
      int            bad;
      for (int i = 0; i < DEPTH; i++) ram[i] = WL'(i);

      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);

      // Cycle-exact latency and throughput: addr 0x10, len 4, m_ready held high
      m_ready = 1'b1;
      send_cmd(8'h10, 4);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check($sformatf("t1_enb_c%0d", k), {63'd0, enb}, {63'd0, (k <= 4)});
         check($sformatf("t1_valid_c%0d", k), {63'd0, m_valid}, {63'd0, (k >= 3 && k <= 6)});
         check($sformatf("t1_cmd_ready_c%0d", k), {63'd0, cmd_ready}, {63'd0, (k >= 7)});
         if (k <= 4) check($sformatf("t1_addrb_c%0d", k), {56'd0, addrb}, 64'(16 + k - 1));
      end
      check("t1_drained", 64'(sbq.size()), 64'd0);

      // Backpressure: len 8 with m_ready low for 10 cycles
      m_ready = 1'b0;
      enb_cnt = 0;
      a = AW'($urandom_range(0, DEPTH - 1));
      send_cmd(a, 8);
      repeat (10) @(negedge clk);
      check("t2_reads_during_stall", 64'(enb_cnt), 64'd3);
      check("t2_enb_held_low", {63'd0, enb}, 64'd0);
      check("t2_buffered", 64'(sbq.size()), 64'd8);
      @(posedge clk); #1;
      m_ready = 1'b1;
      wait_idle(60);
      check("t2_total_reads", 64'(enb_cnt), 64'd8);
      check("t2_drained", 64'(sbq.size()), 64'd0);

      // Address wrap
      addr_log.delete();
      send_cmd(AW'(254), 4);
      wait_idle(40);
      check("t3_nreads", 64'(addr_log.size()), 64'd4);
      if (addr_log.size() == 4) begin
         check("t3_addr0", {56'd0, addr_log[0]}, 64'd254);
         check("t3_addr1", {56'd0, addr_log[1]}, 64'd255);
         check("t3_addr2", {56'd0, addr_log[2]}, 64'd0);
         check("t3_addr3", {56'd0, addr_log[3]}, 64'd1);
      end

      // Zero-length command
      enb_cnt = 0;
      send_cmd(AW'($urandom_range(0, DEPTH - 1)), 0);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         check($sformatf("t4_busy_c%0d", k), {63'd0, busy}, 64'd0);
         check($sformatf("t4_cmd_ready_c%0d", k), {63'd0, cmd_ready}, 64'd1);
      end
      check("t4_no_reads", 64'(enb_cnt), 64'd0);

      // Full-depth command under random backpressure with random RAM contents
      for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
      enb_cnt = 0;
      addr_log.delete();
      a = AW'($urandom_range(0, DEPTH - 1));
      rand_mode = 1'b1;
      send_cmd(a, DEPTH);
      wait_idle(DEPTH * 12);
      check("t5_total_reads", 64'(enb_cnt), 64'(DEPTH));
      check("t5_drained", 64'(sbq.size()), 64'd0);
      bad = 0;
      for (int k = 0; k < addr_log.size(); k++)
         if (int'(addr_log[k]) != (int'(a) + k) % DEPTH) bad++;
      check("t5_addr_sequence_errors", 64'(bad), 64'd0);

      // A few random commands, still under random backpressure
      for (int n = 0; n < 4; n++) begin
         send_cmd(AW'($urandom_range(0, DEPTH - 1)), $urandom_range(1, 40));
         wait_idle(600);
         check($sformatf("t5_rand%0d_drained", n), 64'(sbq.size()), 64'd0);
      end
      rand_mode = 1'b0;
      @(posedge clk); #1;
      m_ready = 1'b1;

      // Reset in cycle 5 of a len-16 command, then a clean restart
      send_cmd(AW'($urandom_range(0, DEPTH - 1)), 16);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sbq.delete();
      @(negedge clk);
      check_reset_values("t6");
      check("t6_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      enb_cnt = 0;
      addr_log.delete();
      a = AW'($urandom_range(0, DEPTH - 1));
      send_cmd(a, 5);
      wait_idle(60);
      check("t6_reads", 64'(enb_cnt), 64'd5);
      if (addr_log.size() > 0) check("t6_first_addr", {56'd0, addr_log[0]}, {56'd0, a});
      check("t6_drained", 64'(sbq.size()), 64'd0);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
